// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package pipe_hazard_ctrl_pkg;

    // Sequencer state encoding.
    localparam logic [1:0] ST_BOOT     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] ST_FLUSH    = 2'd3;

    typedef enum logic [1:0] {
        S_BOOT     = ST_BOOT,
        S_RUN      = ST_RUN,
        S_MEM_WAIT = ST_MEM_WAIT,
        S_FLUSH    = ST_FLUSH
    } state_t;

    // Hard-wired zero register; writes to it are discarded, so it never creates a hazard.
    localparam logic [4:0] REG_X0 = 5'd0;

    // Fetch starts here once the boot hold ends.
    localparam logic [63:0] PC_BOOT_ADDR     = 64'h0000_0000_8000_0000;
    localparam int          DEF_BOOT_CYCLES  = 4;
    localparam int          DEF_FLUSH_CYCLES = 1;
    localparam int          DEF_CNT_WIDTH    = 32;

    // True when a used source register matches a non-x0 destination.
    function automatic logic src_match(input logic [4:0] rs, input logic used, input logic [4:0] rd);
        return used && (rs == rd) && (rd != REG_X0);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the hazard sequencer and the pipeline datapath.
// Latency: n/a (wiring only).
// Backpressure: n/a; enables/flushes are the pipeline's stall mechanism.
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) ();

    // Hazard sources observed in the pipeline.
    logic [4:0]           id_rs1;
    logic [4:0]           id_rs2;
    logic                 id_rs1_used;
    logic                 id_rs2_used;
    logic                 ex_valid;
    logic                 ex_mem_read;
    logic [4:0]           ex_rd;
    logic                 ex_branch_taken;
    logic                 dmem_busy;
    logic                 div_busy;

    // Stage register controls.
    logic                 pc_en;
    logic                 if_id_en;
    logic                 id_ex_en;
    logic                 ex_mem_en;
    logic                 mem_wb_en;
    logic                 if_id_flush;
    logic                 id_ex_flush;
    logic                 pc_redirect;

    // Performance counters.
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;

    // Sequencer side.
    modport master (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_valid, ex_mem_read, ex_rd, ex_branch_taken,
        input  dmem_busy, div_busy,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, pc_redirect,
        output stall_cnt, flush_cnt
    );

    // Datapath side.
    modport slave (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_valid, ex_mem_read, ex_rd, ex_branch_taken,
        output dmem_busy, div_busy,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, pc_redirect,
        input  stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID source registers and a load in EX.
// Latency: purely combinational, same cycle.
// Backpressure: none; the result only feeds the sequencer's stall decision.
module pipe_hazard_ctrl_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       load_use
);

    // A live load in EX whose destination is read by ID needs one bubble.
    always_comb begin
        load_use = ex_valid && ex_mem_read &&
                   (src_match(id_rs1, id_rs1_used, ex_rd) ||
                    src_match(id_rs2, id_rs2_used, ex_rd));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: boot hold, load-use, redirect, dmem/div stalls.
// Latency: enables/flushes/redirect are combinational from state+inputs; counters update next edge.
// Backpressure: dmem_busy freezes every stage; div_busy and load-use freeze the front end only.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES  = DEF_BOOT_CYCLES,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.master bus
);

    // A zero-length boot hold would never release fetch cleanly, so clamp to 1.
    localparam int                 BOOT_EFF   = (BOOT_CYCLES < 1) ? 1 : BOOT_CYCLES;
    localparam int                 BOOT_W     = (BOOT_EFF > 1) ? $clog2(BOOT_EFF) : 1;
    localparam logic [BOOT_W-1:0]  BOOT_INIT  = BOOT_W'(BOOT_EFF - 1);
    // Redirect bubbles last 1..3 cycles; the redirect cycle itself is the first one.
    localparam int                 FLUSH_EFF  = (FLUSH_CYCLES < 1) ? 1 :
                                                (FLUSH_CYCLES > 3) ? 3 : FLUSH_CYCLES;
    localparam logic [1:0]         FLUSH_INIT = (FLUSH_EFF > 1) ? 2'(FLUSH_EFF - 2) : 2'd0;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    state_t               state;
    state_t               state_nxt;
    logic [BOOT_W-1:0]    boot_left;
    logic [BOOT_W-1:0]    boot_left_nxt;
    logic [1:0]           flush_left;
    logic [1:0]           flush_left_nxt;
    logic [CNT_WIDTH-1:0] stall_q;
    logic [CNT_WIDTH-1:0] redir_q;
    logic                 load_use;

    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, pc_redirect;

    pipe_hazard_ctrl_hazard_detect u_hazard_detect (
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_rs1_used (bus.id_rs1_used),
        .id_rs2_used (bus.id_rs2_used),
        .ex_valid    (bus.ex_valid),
        .ex_mem_read (bus.ex_mem_read),
        .ex_rd       (bus.ex_rd),
        .load_use    (load_use)
    );

    // State and sequencing counters; reset aborts any in-flight redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_BOOT;
            boot_left  <= BOOT_INIT;
            flush_left <= 2'd0;
        end else begin
            state      <= state_nxt;
            boot_left  <= boot_left_nxt;
            flush_left <= flush_left_nxt;
        end
    end

    // Next state and stage controls, in priority order: dmem wait, redirect, divide, load-use.
    always_comb begin
        state_nxt      = state;
        boot_left_nxt  = boot_left;
        flush_left_nxt = flush_left;
        pc_en          = 1'b0;
        if_id_en       = 1'b0;
        id_ex_en       = 1'b0;
        ex_mem_en      = 1'b0;
        mem_wb_en      = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        pc_redirect    = 1'b0;
        case (state)
            S_BOOT: begin
                if (boot_left == '0) begin
                    state_nxt = S_RUN;
                end else begin
                    boot_left_nxt = boot_left - BOOT_W'(1);
                end
            end
            S_FLUSH: begin
                // Bubbles keep being injected; a dmem wait freezes the countdown.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (!bus.dmem_busy) begin
                    pc_en     = 1'b1;
                    if_id_en  = 1'b1;
                    id_ex_en  = 1'b1;
                    ex_mem_en = 1'b1;
                    mem_wb_en = 1'b1;
                    if (flush_left == 2'd0) begin
                        state_nxt = S_RUN;
                    end else begin
                        flush_left_nxt = flush_left - 2'd1;
                    end
                end
            end
            default: begin
                // RUN and MEM_WAIT: once dmem releases, the RUN rules apply in that same cycle.
                if (bus.dmem_busy) begin
                    state_nxt = S_MEM_WAIT;
                end else begin
                    state_nxt = S_RUN;
                    if (bus.ex_valid && bus.ex_branch_taken) begin
                        pc_redirect = 1'b1;
                        pc_en       = 1'b1;
                        if_id_en    = 1'b1;
                        id_ex_en    = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        if (FLUSH_EFF > 1) begin
                            state_nxt      = S_FLUSH;
                            flush_left_nxt = FLUSH_INIT;
                        end
                    end else if (bus.div_busy) begin
                        // Back end drains; the datapath turns EX/MEM's input into a bubble.
                        ex_mem_en = 1'b1;
                        mem_wb_en = 1'b1;
                    end else if (load_use) begin
                        // Hold IF and ID, push a bubble into EX for exactly one cycle.
                        id_ex_en    = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                        id_ex_flush = 1'b1;
                    end else begin
                        pc_en     = 1'b1;
                        if_id_en  = 1'b1;
                        id_ex_en  = 1'b1;
                        ex_mem_en = 1'b1;
                        mem_wb_en = 1'b1;
                    end
                end
            end
        endcase
    end

    // Saturating performance counters; boot-hold cycles are not stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            redir_q <= '0;
        end else begin
            if (state != S_BOOT && !pc_en && stall_q != CNT_MAX) begin
                stall_q <= stall_q + CNT_WIDTH'(1);
            end
            if (pc_redirect && redir_q != CNT_MAX) begin
                redir_q <= redir_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.if_id_en    = if_id_en;
    assign bus.id_ex_en    = id_ex_en;
    assign bus.ex_mem_en   = ex_mem_en;
    assign bus.mem_wb_en   = mem_wb_en;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_flush = id_ex_flush;
    assign bus.pc_redirect = pc_redirect;
    assign bus.stall_cnt   = stall_q;
    assign bus.flush_cnt   = redir_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic.
// Latency: outputs sampled mid-cycle, counters checked against a cycle-level reference.
// Backpressure: dmem_busy/div_busy/load-use stalls exercised directly and at random.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int     BOOT_CYCLES  = 4;
    localparam int     FLUSH_CYCLES = 3;
    localparam int     CNT_WIDTH    = 32;
    localparam longint CMAX         = (64'd1 << CNT_WIDTH) - 1;
    localparam int     VW           = 8 + 2 * CNT_WIDTH;

    // Output vector order: pc_en if_id_en id_ex_en ex_mem_en mem_wb_en if_id_flush id_ex_flush pc_redirect
    localparam logic [7:0] O_IDLE   = 8'b0000_0000;
    localparam logic [7:0] O_RUN    = 8'b1111_1000;
    localparam logic [7:0] O_LU     = 8'b0011_1010;
    localparam logic [7:0] O_DIV    = 8'b0001_1000;
    localparam logic [7:0] O_BRANCH = 8'b1111_1111;
    localparam logic [7:0] O_FLUSH  = 8'b1111_1110;
    localparam logic [7:0] O_FLFRZ  = 8'b0000_0110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

    pipe_hazard_ctrl #(
        .BOOT_CYCLES  (BOOT_CYCLES),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_WIDTH    (CNT_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;

    // Reference model: remaining boot cycles, remaining extra flush cycles, expected counters.
    int     m_boot;
    int     m_flush;
    longint m_stall;
    longint m_fcnt;

    logic [7:0]    exp_out, obs_out;
    logic [VW-1:0] exp_vec, obs_vec;

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic ev, input logic emr, input logic [4:0] rd, input logic br,
                         input logic dm, input logic dv);
        bus.id_rs1          = rs1;
        bus.id_rs2          = rs2;
        bus.id_rs1_used     = u1;
        bus.id_rs2_used     = u2;
        bus.ex_valid        = ev;
        bus.ex_mem_read     = emr;
        bus.ex_rd           = rd;
        bus.ex_branch_taken = br;
        bus.dmem_busy       = dm;
        bus.div_busy        = dv;
    endtask

    function automatic logic [7:0] dut_out();
        return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                bus.if_id_flush, bus.id_ex_flush, bus.pc_redirect};
    endfunction

    // Expected controls from the hazard rules and the model's position in boot/flush.
    function automatic logic [7:0] model_out();
        logic lu;
        lu = bus.ex_valid && bus.ex_mem_read && bus.ex_rd != 5'd0 &&
             ((bus.id_rs1_used && bus.id_rs1 == bus.ex_rd) || (bus.id_rs2_used && bus.id_rs2 == bus.ex_rd));
        if (m_boot > 0)                          return O_IDLE;
        if (m_flush > 0)                         return bus.dmem_busy ? O_FLFRZ : O_FLUSH;
        if (bus.dmem_busy)                       return O_IDLE;
        if (bus.ex_valid && bus.ex_branch_taken) return O_BRANCH;
        if (bus.div_busy)                        return O_DIV;
        if (lu)                                  return O_LU;
        return O_RUN;
    endfunction

    task automatic model_reset();
        m_boot  = BOOT_CYCLES;
        m_flush = 0;
        m_stall = 0;
        m_fcnt  = 0;
    endtask

    // Called at posedge+1 with inputs driven: predicts, samples at mid-cycle, advances the model.
    task automatic run_cycle();
        logic dm;
        exp_out = model_out();
        exp_vec = {exp_out, CNT_WIDTH'(m_stall), CNT_WIDTH'(m_fcnt)};
        dm = bus.dmem_busy;
        #4;
        obs_out = dut_out();
        obs_vec = {obs_out, bus.stall_cnt, bus.flush_cnt};
        @(posedge clk);
        if (m_boot > 0) begin
            m_boot--;
        end else begin
            if (!exp_out[7] && m_stall < CMAX) m_stall++;
            if (exp_out[0]) begin
                if (m_fcnt < CMAX) m_fcnt++;
                m_flush = FLUSH_CYCLES - 1;
            end else if (m_flush > 0 && !dm) begin
                m_flush--;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        int low;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #3;
        checks++;
        if ({dut_out(), bus.stall_cnt, bus.flush_cnt} !== '0)
            $display("FAIL reset_values: got %h/%0d/%0d expected 0/0/0", dut_out(), bus.stall_cnt, bus.flush_cnt);
        else passes++;
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        low = 0;
        for (int i = 0; i < BOOT_CYCLES + 3; i++) begin
            run_cycle();
            if (!obs_out[7]) low++;
            checks++;
            if (obs_vec !== exp_vec) $display("FAIL boot cyc%0d: got %h expected %h", i, obs_vec, exp_vec);
            else passes++;
        end
        checks++;
        if (low != BOOT_CYCLES) $display("FAIL boot_len: got %0d expected %0d", low, BOOT_CYCLES);
        else passes++;
        checks++;
        if (bus.stall_cnt !== '0 || obs_out !== O_RUN)
            $display("FAIL boot_end: got stall %0d out %b expected 0 %b", bus.stall_cnt, obs_out, O_RUN);
        else passes++;
    endtask

    task automatic test_load_use();
        longint s0;
        s0 = m_stall;
        drive(5, 9, 1, 0, 1, 1, 5, 0, 0, 0);
        run_cycle();
        checks++;
        if (obs_vec !== exp_vec || obs_out !== O_LU)
            $display("FAIL load_use_stall: got %h expected %h", obs_vec, exp_vec);
        else passes++;
        drive(5, 9, 1, 0, 0, 0, 0, 0, 0, 0);
        run_cycle();
        checks++;
        if (obs_vec !== exp_vec || obs_out !== O_RUN)
            $display("FAIL load_use_release: got %h expected %h", obs_vec, exp_vec);
        else passes++;
        checks++;
        if (bus.stall_cnt !== CNT_WIDTH'(s0 + 1))
            $display("FAIL load_use_cnt: got %0d expected %0d", bus.stall_cnt, s0 + 1);
        else passes++;
    endtask

    task automatic test_no_hazard();
        logic [7:0] want [3];
        want = '{O_RUN, O_RUN, O_LU};
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: drive(0, 0, 1, 1, 1, 1, 0, 0, 0, 0);   // x0 destination
                1: drive(5, 5, 0, 0, 1, 1, 5, 0, 0, 0);   // sources not read
                default: drive(3, 7, 0, 1, 1, 1, 7, 0, 0, 0); // rs2 match
            endcase
            run_cycle();
            checks++;
            if (obs_vec !== exp_vec || obs_out !== want[i])
                $display("FAIL no_hazard case%0d: got %h expected %h", i, obs_vec, exp_vec);
            else passes++;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_cycle();
    endtask

    task automatic test_div();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) drive(4, 0, 1, 0, 1, i[0], 4, 0, 0, 1);  // divide busy, with and without load-use
            else       drive(4, 0, 1, 0, 0, 0, 0, 0, 0, 0);
            run_cycle();
            checks++;
            if (obs_vec !== exp_vec || obs_out !== ((i < 2) ? O_DIV : O_RUN))
                $display("FAIL div cyc%0d: got %h expected %h", i, obs_vec, exp_vec);
            else passes++;
        end
    endtask

    task automatic test_branch_flush();
        longint f0;
        f0 = m_fcnt;
        drive(6, 0, 1, 0, 1, 1, 6, 1, 0, 0);  // taken branch plus load-use
        run_cycle();
        checks++;
        if (obs_vec !== exp_vec || obs_out !== O_BRANCH)
            $display("FAIL branch_redirect: got %h expected %h", obs_vec, exp_vec);
        else passes++;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < FLUSH_CYCLES; i++) begin
            run_cycle();
            checks++;
            if (obs_vec !== exp_vec || obs_out !== ((i < FLUSH_CYCLES - 1) ? O_FLUSH : O_RUN))
                $display("FAIL branch_flush cyc%0d: got %h expected %h", i, obs_vec, exp_vec);
            else passes++;
        end
        checks++;
        if (bus.flush_cnt !== CNT_WIDTH'(f0 + 1))
            $display("FAIL branch_cnt: got %0d expected %0d", bus.flush_cnt, f0 + 1);
        else passes++;
    endtask

    task automatic test_mem_wait();
        longint s0;
        s0 = m_stall;
        for (int i = 0; i < 3 + 1 + FLUSH_CYCLES; i++) begin
            if (i < 3)       drive(0, 0, 0, 0, 1, 0, 2, 1, 1, 0);
            else if (i == 3) drive(0, 0, 0, 0, 1, 0, 2, 1, 0, 0);
            else             drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            run_cycle();
            checks++;
            if (obs_vec !== exp_vec || obs_out !== ((i < 3) ? O_IDLE : (i == 3) ? O_BRANCH :
                                                    (i < 3 + FLUSH_CYCLES) ? O_FLUSH : O_RUN))
                $display("FAIL mem_wait cyc%0d: got %h expected %h", i, obs_vec, exp_vec);
            else passes++;
            if (i == 3) begin
                checks++;
                if (bus.stall_cnt !== CNT_WIDTH'(s0 + 3))
                    $display("FAIL mem_wait_cnt: got %0d expected %0d", bus.stall_cnt, s0 + 3);
                else passes++;
            end
        end
    endtask

    task automatic test_flush_dmem();
        logic [7:0] want [6];
        want = '{O_BRANCH, O_FLFRZ, O_FLFRZ, O_FLUSH, O_FLUSH, O_RUN};
        for (int i = 0; i < 6; i++) begin
            if (i == 0)     drive(0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
            else if (i < 3) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            else            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            run_cycle();
            checks++;
            if (obs_vec !== exp_vec || obs_out !== want[i])
                $display("FAIL flush_dmem cyc%0d: got %h expected %h", i, obs_vec, exp_vec);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_flush();
        int low;
        drive(0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        run_cycle();
        drive(0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        run_cycle();
        checks++;
        if (obs_out !== O_FLUSH) $display("FAIL pre_reset_flush: got %b expected %b", obs_out, O_FLUSH);
        else passes++;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({dut_out(), bus.stall_cnt, bus.flush_cnt} !== '0)
            $display("FAIL async_reset: got %h/%0d/%0d expected 0/0/0", dut_out(), bus.stall_cnt, bus.flush_cnt);
        else passes++;
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        low = 0;
        for (int i = 0; i < BOOT_CYCLES + 2; i++) begin
            run_cycle();
            if (!obs_out[7]) low++;
            checks++;
            if (obs_vec !== exp_vec) $display("FAIL reboot cyc%0d: got %h expected %h", i, obs_vec, exp_vec);
            else passes++;
        end
        checks++;
        if (low != BOOT_CYCLES) $display("FAIL reboot_len: got %0d expected %0d", low, BOOT_CYCLES);
        else passes++;
    endtask

    task automatic test_random();
        logic [4:0] rs1, rs2, rd;
        logic       ev, br, dv;
        for (int i = 0; i < 400; i++) begin
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 3));
            ev  = ($urandom_range(0, 3) != 0);
            br  = ($urandom_range(0, 5) == 0);
            dv  = ($urandom_range(0, 5) == 0) && !(ev && br);
            drive(rs1, rs2, 1'($urandom), 1'($urandom), ev, 1'($urandom), rd, br,
                  ($urandom_range(0, 4) == 0), dv);
            run_cycle();
            checks++;
            if (obs_vec !== exp_vec) $display("FAIL random cyc%0d: got %h expected %h", i, obs_vec, exp_vec);
            else passes++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_div();
        test_branch_flush();
        test_mem_wait();
        test_flush_dmem();
        test_reset_mid_flush();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
